// File: rtl/dbg_pkg.sv
// Shared constants and types for the host-debug command sequencer.
package dbg_pkg;

   localparam logic [7:0] OP_ECHO = 8'h00;
   localparam logic [7:0] OP_RD   = 8'h01;
   localparam logic [7:0] OP_WR   = 8'h02;
   localparam logic [7:0] OP_HALT = 8'h03;
   localparam logic [7:0] OP_RUN  = 8'h04;

   localparam logic [7:0] RSP_ACK = 8'hA5;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   localparam int BAUD_CLKS_DEF     = 868;
   localparam int TIMEOUT_BYTES_DEF = 16;

   typedef enum logic [3:0] {
      IDLE,
      ARGS,
      HALT_WAIT,
      RD_REQ,
      RD_TX,
      WR_RX,
      WR_REQ,
      RESP,
      RELEASE
   } state_t;

   // One byte-time is ten bit-times (start, 8 data, stop).
   function automatic int to_limit(input int baud, input int bytes);
      return baud * 10 * bytes;
   endfunction

   function automatic int to_width(input int baud, input int bytes);
      return $clog2(to_limit(baud, bytes) + 1);
   endfunction

endpackage

// File: rtl/dbg_cmd_ctrl_if.sv
// Byte-wide debug memory port, held-request / one-cycle-ack handshake.
interface dbg_cmd_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/dbg_timeout_cnt.sv
// Saturating idle counter: cleared by reload, advanced by en.
module dbg_timeout_cnt #(
   parameter int W     = 18,
   parameter int LIMIT = 138880
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic reload,
   input  logic en,
   output logic expired
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] count;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         count <= '0;
      else if (reload)
         count <= '0;
      else if (en && count != LIM)
         count <= count + 1'b1;
   end

   assign expired = (count == LIM);

endmodule

// File: rtl/dbg_cmd_ctrl.sv
// Host-debug command sequencer: rx FIFO commands, CPU halt, debug
// memory accesses and tx FIFO responses.
module dbg_cmd_ctrl
   import dbg_pkg::*;
#(
   parameter int BAUD_CLKS     = BAUD_CLKS_DEF,
   parameter int TIMEOUT_BYTES = TIMEOUT_BYTES_DEF
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           rx_empty,
   input  logic [7:0]     rx_data,
   output logic           rx_rd,
   input  logic           tx_full,
   output logic [7:0]     tx_data,
   output logic           tx_wr,
   output logic           halt_req,
   input  logic           halt_ack,
   dbg_cmd_ctrl_if.master mem,
   output logic           busy
);

   localparam int LIMIT = to_limit(BAUD_CLKS, TIMEOUT_BYTES);
   localparam int TO_W  = to_width(BAUD_CLKS, TIMEOUT_BYTES);

   state_t      state;
   logic [7:0]  op;
   logic [1:0]  arg_idx;
   logic [15:0] addr;
   logic [15:0] cnt;
   logic        halt_flag;
   logic        pop_ok;
   logic        push_ok;
   logic        to_expired;

   // Strobes stay combinational so they can never fire on empty/full.
   always_comb begin
      pop_ok  = 1'b0;
      push_ok = 1'b0;
      unique case (state)
         IDLE, ARGS, WR_RX: pop_ok = !rx_empty;
         RD_TX:             push_ok = !tx_full;
         RESP:              push_ok = !tx_full &&
                                      (op != OP_HALT || halt_ack);
         default: ;
      endcase
   end

   assign rx_rd         = pop_ok;
   assign tx_wr         = push_ok;
   assign busy          = (state != IDLE);
   assign mem.mem_addr  = addr;

   dbg_timeout_cnt #(
      .W     (TO_W),
      .LIMIT (LIMIT)
   ) u_to (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .reload  (pop_ok),
      .en      ((state == ARGS || state == WR_RX) && rx_empty),
      .expired (to_expired)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= IDLE;
         op            <= '0;
         arg_idx       <= '0;
         addr          <= '0;
         cnt           <= '0;
         halt_flag     <= 1'b0;
         halt_req      <= 1'b0;
         tx_data       <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: if (pop_ok) begin
               op      <= rx_data;
               arg_idx <= '0;
               case (rx_data)
                  OP_ECHO, OP_RD, OP_WR: state <= ARGS;
                  OP_HALT: begin
                     halt_flag <= 1'b1;
                     halt_req  <= 1'b1;
                     tx_data   <= RSP_ACK;
                     state     <= RESP;
                  end
                  OP_RUN: begin
                     halt_flag <= 1'b0;
                     halt_req  <= 1'b0;
                     tx_data   <= RSP_ACK;
                     state     <= RESP;
                  end
                  default: begin
                     tx_data <= RSP_ERR;
                     state   <= RESP;
                  end
               endcase
            end
            ARGS: if (pop_ok) begin
               arg_idx <= arg_idx + 2'd1;
               if (op == OP_ECHO) begin
                  tx_data <= rx_data;
                  state   <= RESP;
               end else begin
                  case (arg_idx)
                     2'd0: addr[7:0]  <= rx_data;
                     2'd1: addr[15:8] <= rx_data;
                     2'd2: cnt[7:0]   <= rx_data;
                     default: begin
                        cnt[15:8] <= rx_data;
                        // Zero-length transfers never touch the CPU.
                        if ({rx_data, cnt[7:0]} == 16'd0) begin
                           tx_data <= RSP_ACK;
                           state   <= (op == OP_WR) ? RESP : IDLE;
                        end else begin
                           halt_req <= 1'b1;
                           state    <= HALT_WAIT;
                        end
                     end
                  endcase
               end
            end else if (to_expired) begin
               tx_data <= RSP_ERR;
               state   <= RESP;
            end
            HALT_WAIT: begin
               halt_req <= 1'b1;
               if (halt_ack) begin
                  if (op == OP_RD) begin
                     mem.mem_req <= 1'b1;
                     mem.mem_we  <= 1'b0;
                     state       <= RD_REQ;
                  end else begin
                     state <= WR_RX;
                  end
               end
            end
            RD_REQ: if (mem.mem_ack) begin
               mem.mem_req <= 1'b0;
               tx_data     <= mem.mem_rdata;
               state       <= RD_TX;
            end
            RD_TX: if (push_ok) begin
               addr <= addr + 16'd1;
               cnt  <= cnt - 16'd1;
               if (cnt == 16'd1) begin
                  state <= RELEASE;
               end else begin
                  mem.mem_req <= 1'b1;
                  state       <= RD_REQ;
               end
            end
            WR_RX: if (pop_ok) begin
               mem.mem_wdata <= rx_data;
               mem.mem_req   <= 1'b1;
               mem.mem_we    <= 1'b1;
               state         <= WR_REQ;
            end else if (to_expired) begin
               tx_data <= RSP_ERR;
               state   <= RELEASE;
            end
            WR_REQ: if (mem.mem_ack) begin
               mem.mem_req <= 1'b0;
               mem.mem_we  <= 1'b0;
               addr        <= addr + 16'd1;
               cnt         <= cnt - 16'd1;
               if (cnt == 16'd1) begin
                  tx_data <= RSP_ACK;
                  state   <= RELEASE;
               end else begin
                  state <= WR_RX;
               end
            end
            RELEASE: begin
               halt_req <= halt_flag;
               state    <= (op == OP_WR) ? RESP : IDLE;
            end
            RESP: if (push_ok) state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// Scoreboard bench for dbg_cmd_ctrl: FIFO/memory/CPU models feed a
// negedge monitor that checks tx bytes, memory accesses and levels.
module tb_dbg_cmd_ctrl;
   import dbg_pkg::*;

   localparam int BAUD = 2;
   localparam int TOB  = 2;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } acc_t;

   typedef struct {
      string name;
      int    sel;
      logic  val;
      logic  act;
   } lvl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_empty = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rd;
   logic       tx_full = 1'b0;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       halt_req;
   logic       halt_ack = 1'b0;
   logic       busy;

   dbg_cmd_ctrl_if mif();

   dbg_cmd_ctrl #(
      .BAUD_CLKS     (BAUD),
      .TIMEOUT_BYTES (TOB)
   ) dut (
      .clk_in   (clk),
      .rst_in   (rst),
      .rx_empty (rx_empty),
      .rx_data  (rx_data),
      .rx_rd    (rx_rd),
      .tx_full  (tx_full),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .halt_req (halt_req),
      .halt_ack (halt_ack),
      .mem      (mif),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] rx_q[$];
   logic [7:0] exp_tx[$];
   acc_t       exp_mem[$];
   lvl_t       lvl_q[$];

   int   checks = 0;
   int   failures = 0;
   logic halt_seen = 1'b0;
   bit   finish_req = 1'b0;

   // rx FIFO: first-word fall-through view refreshed every edge.
   always @(posedge clk) begin
      if (rst)
         rx_q.delete();
      else if (rx_rd && rx_q.size() != 0)
         void'(rx_q.pop_front());
      rx_empty <= (rx_q.size() == 0);
      rx_data  <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   end

   logic [7:0] mem [65536];
   logic       lat;

   always @(posedge clk) begin
      if (rst) begin
         mif.mem_ack   <= 1'b0;
         mif.mem_rdata <= 8'h00;
         lat           <= 1'b0;
         mem[16'h0200] <= 8'h11;
         mem[16'h0201] <= 8'h22;
         mem[16'h0202] <= 8'h33;
      end else begin
         mif.mem_ack <= 1'b0;
         if (mif.mem_req && !mif.mem_ack) begin
            if (lat) begin
               mif.mem_ack <= 1'b1;
               lat         <= 1'b0;
               if (mif.mem_we)
                  mem[mif.mem_addr] <= mif.mem_wdata;
               else
                  mif.mem_rdata <= mem[mif.mem_addr];
            end else begin
               lat <= 1'b1;
            end
         end
      end
   end

   always @(posedge clk)
      halt_ack <= rst ? 1'b0 : halt_req;

   logic [7:0] e8;
   acc_t       ea;
   acc_t       got;
   lvl_t       l;
   logic       a;

   initial begin
      forever begin
         @(negedge clk);
         if (halt_req) halt_seen = 1'b1;
         if (tx_wr) begin
            checks++;
            if (exp_tx.size() == 0) begin
               failures++;
               $display("FAIL tx_extra: got %02h, expected no byte", tx_data);
            end else begin
               e8 = exp_tx.pop_front();
               if (tx_data !== e8) begin
                  failures++;
                  $display("FAIL tx_byte: got %02h, expected %02h", tx_data, e8);
               end
            end
         end
         if (mif.mem_ack) begin
            checks++;
            got = {mif.mem_we, mif.mem_addr, mif.mem_we ? mif.mem_wdata : 8'h00};
            if (exp_mem.size() == 0) begin
               failures++;
               $display("FAIL mem_extra: got we=%0b addr=%04h data=%02h, expected none",
                        got.we, got.addr, got.data);
            end else begin
               ea = exp_mem.pop_front();
               if (got !== ea) begin
                  failures++;
                  $display("FAIL mem_access: got we=%0b addr=%04h data=%02h, expected we=%0b addr=%04h data=%02h",
                           got.we, got.addr, got.data, ea.we, ea.addr, ea.data);
               end
            end
         end
         if (lvl_q.size() != 0) begin
            l = lvl_q.pop_front();
            case (l.sel)
               0: a = halt_req;
               1: a = busy;
               2: a = !(rx_rd | tx_wr | halt_req | mif.mem_req | mif.mem_we | busy) &&
                      tx_data == 8'h00 && mif.mem_addr == 16'h0000 &&
                      mif.mem_wdata == 8'h00;
               3: a = l.act;
               default: a = halt_seen;
            endcase
            if (l.sel == 5) begin
               halt_seen = 1'b0;
            end else begin
               checks++;
               if (a !== l.val) begin
                  failures++;
                  $display("FAIL %s: got %0b, expected %0b", l.name, a, l.val);
               end
               if (l.sel == 4) halt_seen = 1'b0;
            end
         end
         if (finish_req && lvl_q.size() == 0) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      rx_q.push_back(b);
   endtask

   task automatic lvl(input string n, input int s, input logic v);
      lvl_q.push_back('{n, s, v, 1'b0});
   endtask

   task automatic xmem(input logic we, input logic [15:0] ad, input logic [7:0] d);
      exp_mem.push_back({we, ad, d});
   endtask

   task automatic drain(input string n);
      int k;
      k = 0;
      tick(2);
      while ((rx_q.size() != 0 || exp_tx.size() != 0 ||
              exp_mem.size() != 0 || busy) && k < 3000) begin
         tick(1);
         k++;
      end
      lvl_q.push_back('{n, 3, 1'b1, (k < 3000)});
      tick(2);
   endtask

   initial begin
      tick(4);
      rst = 1'b0;
      lvl("reset_outputs", 2, 1'b1);
      tick(2);

      put(OP_ECHO); put(8'h3C);
      exp_tx.push_back(8'h3C);
      drain("echo_drain");
      lvl("echo_no_halt", 4, 1'b0);
      lvl("echo_idle", 1, 1'b0);

      lvl("clr", 5, 1'b0);
      put(OP_RD); put(8'h00); put(8'h02); put(8'h03); put(8'h00);
      xmem(0, 16'h0200, 8'h00); xmem(0, 16'h0201, 8'h00); xmem(0, 16'h0202, 8'h00);
      exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
      drain("rd3_drain");
      lvl("rd3_halt_rose", 4, 1'b1);
      lvl("rd3_halt_fell", 0, 1'b0);

      put(OP_WR); put(8'hFF); put(8'hFF); put(8'h02); put(8'h00);
      put(8'hAA); put(8'hBB);
      xmem(1, 16'hFFFF, 8'hAA); xmem(1, 16'h0000, 8'hBB);
      exp_tx.push_back(RSP_ACK);
      drain("wrwrap_drain");
      lvl("wrwrap_halt_low", 0, 1'b0);

      put(OP_HALT);
      exp_tx.push_back(RSP_ACK);
      drain("halt_drain");
      lvl("halt_held", 0, 1'b1);
      put(OP_RD); put(8'h00); put(8'h02); put(8'h01); put(8'h00);
      xmem(0, 16'h0200, 8'h00);
      exp_tx.push_back(8'h11);
      drain("halted_rd_drain");
      lvl("halt_kept_after_rd", 0, 1'b1);
      put(OP_RUN);
      exp_tx.push_back(RSP_ACK);
      drain("run_drain");
      lvl("run_halt_low", 0, 1'b0);

      lvl("clr", 5, 1'b0);
      put(OP_RD); put(8'h00); put(8'h02); put(8'h00); put(8'h00);
      drain("rd0_drain");
      put(OP_WR); put(8'h00); put(8'h02); put(8'h00); put(8'h00);
      exp_tx.push_back(RSP_ACK);
      drain("wr0_drain");
      lvl("cnt0_no_halt", 4, 1'b0);

      put(8'h7F); put(OP_ECHO); put(8'h5A);
      exp_tx.push_back(RSP_ERR); exp_tx.push_back(8'h5A);
      drain("unknown_drain");

      tx_full = 1'b1;
      put(OP_RD); put(8'h00); put(8'h02); put(8'h03); put(8'h00);
      xmem(0, 16'h0200, 8'h00); xmem(0, 16'h0201, 8'h00); xmem(0, 16'h0202, 8'h00);
      exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
      tick(30);
      lvl("stall_busy", 1, 1'b1);
      for (int i = 0; i < 60; i++) begin
         tx_full = (i % 4 != 0);
         tick(1);
      end
      tx_full = 1'b0;
      drain("stall_drain");

      put(OP_WR); put(8'h00); put(8'h03); put(8'h04); put(8'h00); put(8'h01);
      xmem(1, 16'h0300, 8'h01);
      exp_tx.push_back(RSP_ERR);
      drain("timeout_drain");
      lvl("timeout_halt_low", 0, 1'b0);
      lvl("timeout_idle", 1, 1'b0);

      put(OP_HALT);
      exp_tx.push_back(RSP_ACK);
      drain("halt2_drain");
      put(OP_RD); put(8'h00); put(8'h02);
      tick(10);
      lvl("mid_cmd_busy", 1, 1'b1);
      tick(2);
      rst = 1'b1;
      tick(1);
      lvl("rst_halt_low", 0, 1'b0);
      lvl("rst_idle", 1, 1'b0);
      tick(4);
      rst = 1'b0;
      tick(2);
      put(OP_ECHO); put(8'h55);
      exp_tx.push_back(8'h55);
      drain("post_rst_drain");

      finish_req = 1'b1;
   end

endmodule
